// File: rtl/way_hit_lru_if.sv
// Lookup/refill bus between the tag SRAM read port, the dcache controller and way_hit_lru.
// The controller side drives requests and refills; the LRU block returns the registered result.
interface way_hit_lru_if #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 23,
  parameter int IDX_W = 4,
  parameter int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
);
  logic                      req_valid_i;
  logic [IDX_W-1:0]          req_idx_i;
  logic [TAG_W-1:0]          req_tag_i;
  logic [WAYS*(TAG_W+2)-1:0] way_entry_i;
  logic                      fill_i;
  logic [IDX_W-1:0]          fill_idx_i;
  logic [AGE_W-1:0]          fill_way_i;
  logic                      resp_valid_o;
  logic                      hit_o;
  logic [WAYS-1:0]           hit_way_o;
  logic [AGE_W-1:0]          victim_way_o;
  logic                      victim_dirty_o;

  modport master (
    output req_valid_i, req_idx_i, req_tag_i, way_entry_i, fill_i, fill_idx_i, fill_way_i,
    input  resp_valid_o, hit_o, hit_way_o, victim_way_o, victim_dirty_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_tag_i, way_entry_i, fill_i, fill_idx_i, fill_way_i,
    output resp_valid_o, hit_o, hit_way_o, victim_way_o, victim_dirty_o
  );
endinterface

// File: rtl/way_hit_lru.sv
// N-way tag compare with registered hit result, plus per-set true-LRU ages that nominate
// a victim way (invalid ways first, then the oldest) for the refill path.
module way_hit_lru #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int TAG_W = 23,
  parameter int IDX_W = 4,
  parameter int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  way_hit_lru_if.slave bus
);
  localparam int EW = TAG_W + 2;

  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  way_dirty;
  logic [WAYS-1:0]  way_match;

  logic [AGE_W-1:0] age_q [SETS][WAYS];
  logic [AGE_W-1:0] age_d [SETS][WAYS];

  logic             hit;
  logic [WAYS-1:0]  hit_onehot;
  logic [AGE_W-1:0] hit_idx;
  logic [AGE_W-1:0] victim_idx;
  logic             victim_dirty;
  logic             fill_ok;
  logic             hit_touch;

  logic             resp_valid_q, resp_valid_d;
  logic             hit_q, hit_d;
  logic [WAYS-1:0]  hit_way_q, hit_way_d;
  logic [AGE_W-1:0] victim_way_q, victim_way_d;
  logic             victim_dirty_q, victim_dirty_d;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_valid[gi] = bus.way_entry_i[gi*EW + TAG_W + 1];
      assign way_dirty[gi] = bus.way_entry_i[gi*EW + TAG_W];
      assign way_match[gi] = way_valid[gi] && (bus.way_entry_i[gi*EW +: TAG_W] == bus.req_tag_i);
    end
  endgenerate

  // Descending scans so the lowest-index candidate is the last one to win.
  always_comb begin
    hit          = 1'b0;
    hit_onehot   = '0;
    hit_idx      = '0;
    victim_idx   = '0;
    victim_dirty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        hit           = 1'b1;
        hit_onehot    = '0;
        hit_onehot[w] = 1'b1;
        hit_idx       = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[bus.req_idx_i][w] == AGE_W'(WAYS - 1)) begin
        victim_idx   = AGE_W'(w);
        victim_dirty = way_valid[w] & way_dirty[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_idx   = AGE_W'(w);
        victim_dirty = 1'b0;
      end
    end
  end

  // A fill into the set being hit takes priority; the hit touch is dropped.
  always_comb begin
    age_d     = age_q;
    fill_ok   = bus.fill_i && (32'(bus.fill_way_i) < WAYS);
    hit_touch = bus.req_valid_i && hit && !(fill_ok && (bus.fill_idx_i == bus.req_idx_i));
    if (hit_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == hit_idx)
          age_d[bus.req_idx_i][w] = '0;
        else if (age_q[bus.req_idx_i][w] < age_q[bus.req_idx_i][hit_idx])
          age_d[bus.req_idx_i][w] = age_q[bus.req_idx_i][w] + 1'b1;
      end
    end
    if (fill_ok) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == bus.fill_way_i)
          age_d[bus.fill_idx_i][w] = '0;
        else if (age_q[bus.fill_idx_i][w] < age_q[bus.fill_idx_i][bus.fill_way_i])
          age_d[bus.fill_idx_i][w] = age_q[bus.fill_idx_i][w] + 1'b1;
      end
    end
  end

  always_comb begin
    resp_valid_d   = bus.req_valid_i;
    hit_d          = bus.req_valid_i & hit;
    hit_way_d      = bus.req_valid_i ? hit_onehot : '0;
    victim_way_d   = bus.req_valid_i ? victim_idx : '0;
    victim_dirty_d = bus.req_valid_i & victim_dirty;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
      resp_valid_q   <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      victim_way_q   <= '0;
      victim_dirty_q <= 1'b0;
    end else begin
      age_q          <= age_d;
      resp_valid_q   <= resp_valid_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      victim_way_q   <= victim_way_d;
      victim_dirty_q <= victim_dirty_d;
    end
  end

  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.hit_o          = hit_q;
  assign bus.hit_way_o      = hit_way_q;
  assign bus.victim_way_o   = victim_way_q;
  assign bus.victim_dirty_o = victim_dirty_q;
endmodule

// File: tb/tb_way_hit_lru.sv
// Directed bench for way_hit_lru: a 4-way instance driven from a vector table with
// hand-computed LRU expectations, plus a 2-way instance and an async-reset sequence.
module tb_way_hit_lru;
  localparam int TW = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  way_hit_lru_if #(.WAYS(4), .TAG_W(TW), .IDX_W(4), .AGE_W(2)) if4 ();
  way_hit_lru_if #(.WAYS(2), .TAG_W(TW), .IDX_W(4), .AGE_W(1)) if2 ();

  way_hit_lru #(.WAYS(4), .SETS(16), .TAG_W(TW), .IDX_W(4), .AGE_W(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .bus(if4.slave)
  );
  way_hit_lru #(.WAYS(2), .SETS(16), .TAG_W(TW), .IDX_W(4), .AGE_W(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .bus(if2.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rv;
    logic [3:0]    idx;
    logic [TW-1:0] tag;
    logic [3:0]    v;
    logic [3:0]    d;
    logic          dup;
    logic          fv;
    logic [3:0]    fidx;
    logic [1:0]    fway;
    logic          e_resp;
    logic          e_hit;
    logic [3:0]    e_way;
    logic [1:0]    e_vic;
    logic          e_vd;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic rv, input int idx, input int tag,
                              input logic [3:0] v, input logic [3:0] d, input logic dup,
                              input logic fv, input int fidx, input int fway,
                              input logic er, input logic eh, input logic [3:0] ew,
                              input int evic, input logic evd);
    vec_t m;
    m.rv = rv; m.idx = 4'(idx); m.tag = TW'(tag); m.v = v; m.d = d; m.dup = dup;
    m.fv = fv; m.fidx = 4'(fidx); m.fway = 2'(fway);
    m.e_resp = er; m.e_hit = eh; m.e_way = ew; m.e_vic = 2'(evic); m.e_vd = evd;
    return m;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  // Way w holds tag 100+w; with dup set, ways 1..3 all hold tag 300.
  task automatic drive4(input vec_t t);
    logic [99:0] e;
    logic [TW-1:0] tg;
    for (int w = 0; w < 4; w++) begin
      tg = (t.dup && w > 0) ? TW'(300) : TW'(100 + w);
      e[w*25 +: 25] = {t.v[w], t.d[w], tg};
    end
    if4.req_valid_i = t.rv;
    if4.req_idx_i   = t.idx;
    if4.req_tag_i   = t.tag;
    if4.way_entry_i = e;
    if4.fill_i      = t.fv;
    if4.fill_idx_i  = t.fidx;
    if4.fill_way_i  = t.fway;
  endtask

  task automatic drive2(input logic rv, input int idx, input int t0, input int t1, input int rtag);
    if2.req_valid_i = rv;
    if2.req_idx_i   = 4'(idx);
    if2.req_tag_i   = TW'(rtag);
    if2.way_entry_i = {1'b1, 1'b0, TW'(t1), 1'b1, 1'b0, TW'(t0)};
    if2.fill_i      = 1'b0;
    if2.fill_idx_i  = '0;
    if2.fill_way_i  = '0;
  endtask

  task automatic check4(input string pfx, input int row, input vec_t t);
    chk({pfx, "_resp"}, row, 32'(if4.resp_valid_o), 32'(t.e_resp));
    chk({pfx, "_hit"}, row, 32'(if4.hit_o), 32'(t.e_hit));
    chk({pfx, "_way"}, row, 32'(if4.hit_way_o), 32'(t.e_way));
    chk({pfx, "_vic"}, row, 32'(if4.victim_way_o), 32'(t.e_vic));
    chk({pfx, "_vdirty"}, row, 32'(if4.victim_dirty_o), 32'(t.e_vd));
    $display("%s row %0d: resp=%0b hit=%0b way=%b vic=%0d vd=%0b", pfx, row, if4.resp_valid_o,
             if4.hit_o, if4.hit_way_o, if4.victim_way_o, if4.victim_dirty_o);
  endtask

  task automatic check2(input int row, input logic er, input logic eh, input logic [1:0] ew, input logic ev);
    chk("w2_resp", row, 32'(if2.resp_valid_o), 32'(er));
    chk("w2_hit", row, 32'(if2.hit_o), 32'(eh));
    chk("w2_way", row, 32'(if2.hit_way_o), 32'(ew));
    chk("w2_vic", row, 32'(if2.victim_way_o), 32'(ev));
    $display("w2 row %0d: resp=%0b hit=%0b way=%b vic=%0d", row, if2.resp_valid_o, if2.hit_o,
             if2.hit_way_o, if2.victim_way_o);
  endtask

  vec_t idle;
  vec_t zero_exp;
  vec_t tmp;

  initial begin
    idle     = mk(0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    zero_exp = idle;
    // Set 5, all valid: ages start [0,1,2,3] and evolve as commented.
    tbl[0]  = mk(1, 5, 103, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b1000, 3, 0); // -> [1,2,3,0]
    tbl[1]  = mk(1, 5, 101, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b0010, 2, 0); // -> [2,0,3,1]
    tbl[2]  = mk(1, 5, 100, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b0001, 2, 0); // -> [0,1,3,2]
    tbl[3]  = mk(1, 5, 102, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b0100, 2, 0); // -> [1,2,0,3]
    tbl[4]  = mk(1, 5, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 0);
    tbl[5]  = mk(1, 5, 103, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b1000, 3, 0); // -> [2,3,1,0]
    tbl[6]  = mk(1, 5, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 0);
    tbl[7]  = mk(1, 5, 102, 4'b1011, 4'b0100, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 0);
    tbl[8]  = mk(1, 5, 200, 4'hF, 4'b0011, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 1);
    tbl[9]  = mk(1, 5, 101, 4'hF, 4'b0011, 0, 0, 0, 0, 1, 1, 4'b0010, 1, 1); // -> [3,0,2,1]
    tbl[10] = mk(1, 15, 300, 4'hF, 4'h0, 1, 0, 0, 0, 1, 1, 4'b0010, 3, 0);   // -> [1,0,2,3]
    tbl[11] = mk(1, 15, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 0);
    tbl[12] = mk(0, 15, 300, 4'hF, 4'h0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    tbl[13] = mk(1, 0, 103, 4'b0101, 4'hF, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 0);
    tbl[14] = mk(1, 7, 100, 4'hF, 4'h0, 0, 1, 7, 2, 1, 1, 4'b0001, 3, 0);    // fill wins: [1,2,0,3]
    tbl[15] = mk(0, 0, 0, 4'hF, 4'h0, 0, 1, 7, 3, 0, 0, 4'b0000, 0, 0);      // -> [2,3,1,0]
    tbl[16] = mk(1, 7, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 0);
    tbl[17] = mk(1, 8, 103, 4'hF, 4'h0, 0, 1, 9, 3, 1, 1, 4'b1000, 3, 0);    // both sets touched
    tbl[18] = mk(1, 8, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 0);
    tbl[19] = mk(1, 9, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 0);

    drive4(idle);
    drive2(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check4("reset", 0, zero_exp);
    check2(0, 0, 0, 2'b00, 0);

    for (int i = 0; i < 20; i++) begin
      drive4(tbl[i]);
      @(posedge clk);
      #1;
      check4("w4", i, tbl[i]);
    end
    drive4(idle);

    // Two-way instance: hit in set 3, miss shows way1 oldest, duplicate tags pick way0.
    drive2(1, 3, 5, 6, 5);
    @(posedge clk); #1 check2(1, 1, 1, 2'b01, 1);
    drive2(1, 3, 5, 6, 9);
    @(posedge clk); #1 check2(2, 1, 0, 2'b00, 1);
    drive2(1, 4, 5, 5, 5);
    @(posedge clk); #1 check2(3, 1, 1, 2'b01, 1);

    // Async reset with a request in flight; set 5 ages were [3,0,2,1], set 7 [2,3,1,0].
    tmp = mk(1, 5, 100, 4'hF, 4'h0, 0, 0, 0, 0, 1, 1, 4'b0001, 0, 0);
    drive4(tmp);
    @(posedge clk); #1 check4("pre_rst", 0, tmp);
    #2 rst_n = 1'b0;
    #1 check4("in_rst", 0, zero_exp);
    check2(4, 0, 0, 2'b00, 0);
    drive4(idle);
    drive2(0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1 check4("post_rst", 0, zero_exp);
    tmp = mk(1, 5, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 0);
    drive4(tmp);
    @(posedge clk); #1 check4("age_rst", 5, tmp);
    tmp = mk(1, 7, 200, 4'hF, 4'h0, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 0);
    drive4(tmp);
    @(posedge clk); #1 check4("age_rst", 7, tmp);
    drive4(idle);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/way_hit_lru.md
Name: way_hit_lru

Overview:
- Parametrised N-way set-associative hit-select and replacement block for the data cache.
- Compares a request tag against the tag entries of all ways of the indexed set and reports a registered hit result and the way that hit.
- Keeps true-LRU age state per set and nominates a victim way, with its dirty flag, for the miss/refill path.
- Sits between the tag SRAM read port and the dcache controller FSM.

Parameters:
WAYS, 2, associativity; 2..8.
SETS, 16, number of sets; power of two.
TAG_W, 23, tag width.
IDX_W, 4, set index width; equals log2(SETS).
AGE_W, derived, log2(WAYS) (minimum 1); width of one age counter.

Ports:
clk_i  in  1  clock; rising edge.
rst_i  in  1  reset; asynchronous, active-low.
req_valid_i  in  1  lookup request this cycle.
req_idx_i  in  IDX_W  set index of the lookup.
req_tag_i  in  TAG_W  tag of the lookup.
way_entry_i  in  WAYS*(TAG_W+2)  tag entries of the indexed set. Way w occupies slice [w*(TAG_W+2) +: TAG_W+2], laid out as {valid, dirty, tag}.
fill_i  in  1  refill completed; makes fill_way_i MRU in fill_idx_i.
fill_idx_i  in  IDX_W  set index of the refill.
fill_way_i  in  AGE_W  way index of the refill.
resp_valid_o  out  1  result valid; one cycle after req_valid_i.
hit_o  out  1  lookup hit.
hit_way_o  out  WAYS  one-hot hit way; all zero on miss.
victim_way_o  out  AGE_W  replacement way index.
victim_dirty_o  out  1  dirty bit of the victim way.

Behaviour:
- Reset (rst_i low, asynchronous; any cycle, including mid-request):
  - all outputs go to 0;
  - the age of way w in every set goes to w;
  - any in-flight request is discarded and produces no resp_valid_o.
- Match rule: way w matches when valid_w = 1 and tag_w == req_tag_i. The dirty bit is ignored for matching.
- Multiple matches: lowest-index way wins. hit_way_o is always one-hot or zero.
- Latency:
  - req_valid_i sampled at edge N; hit_o, hit_way_o, victim_way_o, victim_dirty_o are registered and valid with resp_valid_o during cycle N+1.
  - When resp_valid_o = 0, all result outputs are 0.
  - Back-to-back requests are accepted every cycle; there is no stall.
- Victim selection, computed from the pre-update ages of req_idx_i and way_entry_i:
  1. lowest-index way with valid = 0 if one exists;
  2. otherwise the way with age WAYS-1 (oldest).
  - victim_dirty_o = valid and dirty bits of the chosen way, ANDed.
  - Victim outputs are produced on both hit and miss.
- Age state:
  - SETS x WAYS counters of AGE_W bits.
  - Within a set the ages are always a permutation of 0..WAYS-1.
- Touch(set s, way k): every way in s with age < age_k increments; way k's age goes to 0; all other ages are unchanged.
- Update triggers, applied at the clock edge:
  - a hitting request touches (req_idx_i, winning way);
  - fill_i touches (fill_idx_i, fill_way_i);
  - a miss does not touch.
- Simultaneous hit and fill:
  - different sets: both touches apply;
  - same set: only the fill touch applies; the hit touch is dropped.
  - The lookup result is still reported normally and is computed from the pre-edge ages.
- fill_way_i >= WAYS (possible when WAYS is not a power of two): fill ignored.
- The block reads the ages of the request set from state registered before the edge. There is no bypass of same-cycle updates into the current lookup.
- req_idx_i and fill_idx_i at the maximum value (SETS-1) address the last set; there is no wrap-around.

Test Plan:
- WAYS=2, after reset: request idx 3 with way0 = {1,0,T}, way1 = {1,0,T'}, req_tag = T -> next cycle resp_valid_o=1, hit_o=1, hit_way_o=2'b01. Ages of set 3 become way0=0, way1=1, so the following miss reports victim_way_o=1.
- Both ways valid with identical tags equal to req_tag -> hit_way_o=2'b01 (lowest index wins).
- WAYS=4, all ways valid and clean, reset ages:
  - hits to ways 3, 1, 0, 2 in set 5, then a miss in set 5 -> victim_way_o=3;
  - then a hit to 3 followed by a miss -> victim_way_o=1.
- Miss with way2 = {0,1,X} and all other ways valid -> victim_way_o=2, victim_dirty_o=0 (invalid-first; dirty masked by valid).
- All ways valid, oldest way dirty -> victim_dirty_o=1.
- Same cycle: hit to way0 in set 7 and fill_i with idx 7, way 2 -> response hit_way_o=one-hot way0. Set 7 ages show way2=0; way0 is not made MRU.
- rst_i asserted low asynchronously while req_valid_i=1 -> outputs drop to 0 immediately. After release there is no resp_valid_o for that request, and all ages are restored to age(w)=w.
